game_screen_sequencer: RTL and testbench
========================================

# game_screen_sequencer

Top-level game flow controller. It decides which screen drawer (level, win screen, lose screen, game-over screen) currently owns the background map and sprite outputs feeding the VGA renderer. It consumes the active level's `win`/`lose` flags, the jump button and a per-frame tick. It drives the screen select mux, tracks remaining lives, and issues a restart pulse to the level drawer. It runs entirely in the `vga_clock` domain.

## Interface
Parameters:
- `LIVES`, 3: lives loaded at reset and on restart after win/game over; legal range 1..3.
- `HOLD_FRAMES`, 120: frames a result screen is shown before input is accepted or auto-return occurs; legal range 1..255.

Ports:
- `vga_clock` in 1: sole clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low; one clock; asynchronous assert, used directly (no internal sync).
- `frame_tick` in 1: one-cycle pulse once per frame (start of vertical blank).
- `win` in 1: level-sensitive flag from level drawer.
- `lose` in 1: level-sensitive flag from level drawer.
- `jump_button` in 1: raw push button, active-low, asynchronous to `vga_clock`.
- `screen_sel` out 2: 0 = PLAY, 1 = WIN, 2 = LOSE, 3 = OVER; drives the drawer output mux.
- `level_reset_n` out 1: active-low restart to level drawer.
- `lives` out 2: remaining lives.
- `hold_frames_left` out 8: remaining hold count, for on-screen countdown.

## Operation
- Button path: two-flop synchronizer on `jump_button`, then an edge register. `press` is a one-cycle pulse on a synchronized 1→0 transition. A held button produces exactly one press.
- State register values equal `screen_sel` encoding; `screen_sel` is the state register.
- `armed` flag: cleared on every entry to PLAY and by reset. Set on the first `frame_tick` while in PLAY. `win`/`lose` are ignored while `armed`=0, which masks stale flags from the previous level.
- PLAY, armed, `win`=1 → WIN. `win` has priority when `win` and `lose` are both 1 in the same cycle.
- PLAY, armed, `lose`=1, `win`=0: `lives` decrements. If `lives` was 1 → OVER with `lives`=0. Otherwise → LOSE.
- Any entry to WIN/LOSE/OVER loads `hold_frames_left` = HOLD_FRAMES.
- In WIN/LOSE/OVER, each `frame_tick` decrements `hold_frames_left`, saturating at 0.
- WIN or OVER: a `press` with `hold_frames_left`==0 → PLAY and `lives` reloads to LIVES. A press while the hold count is nonzero is discarded, not queued.
- LOSE: automatically → PLAY on the cycle after `hold_frames_left` reaches 0; `lives` is unchanged. `press` is ignored in LOSE.
- Every transition into PLAY drives `level_reset_n` low for exactly one cycle: the first cycle with `screen_sel`=0.
- In PLAY, `hold_frames_left` holds 0.

## Timing
- Reset (`reset`=0), all outputs immediately: `screen_sel`=0, `lives`=LIVES, `hold_frames_left`=0, `level_reset_n`=0, `armed`=0, synchronizer flops=1 (released).
- First rising edge after `reset` deasserts: `level_reset_n`→1. The level starts in PLAY, unarmed.
- Button latency: `press` pulses 3 cycles after the falling edge of `jump_button` (2 sync + 1 edge). The state changes on the next edge, so `screen_sel` updates 4 cycles after the button edge.
- `win`/`lose` to `screen_sel`: 1 cycle. `lives` and `hold_frames_left` update on the same edge as the state.
- `frame_tick` coincident with a state entry: the load wins, and that tick is not counted.
- `frame_tick` coincident with PLAY entry: `armed` stays 0. Arming needs a tick while already in PLAY.
- `reset` asserted mid-hold or mid-pulse: all outputs return immediately to their reset values. No partial pulse widening.
- `lives` never underflows. OVER is the only state in which `lives`=0.

## Test plan
- Reset release with `win`=1 held: `screen_sel` stays 0 until the first `frame_tick`. The next cycle after that tick gives `screen_sel`=1 and `hold_frames_left`=120.
- WIN with HOLD_FRAMES=4: a press after 2 ticks is ignored. After 4 ticks, press → `screen_sel`=0 four cycles after the button edge, one-cycle `level_reset_n`=0, `lives`=3.
- Three armed `lose` events: `lives` goes 2 → 1 → 0. `screen_sel` sequence is 2, auto-return 0, 2, auto-return 0, then 3.
- LOSE auto-return: `screen_sel`=0 exactly 1 cycle after the HOLD_FRAMES-th tick; `lives` is unchanged; `level_reset_n` is low for 1 cycle.
- `win` and `lose` both 1 in the same armed cycle → WIN; `lives` is unchanged.
- Button held low for 1000 cycles in WIN with hold 0 → exactly one transition. `reset` asserted mid-hold → `screen_sel`=0, `lives`=3, `hold_frames_left`=0 immediately.

Source files
------------

// File: rtl/game_screen_sequencer.sv
// Top-level game flow controller: picks which screen drawer owns the VGA outputs,
// tracks remaining lives and issues a one-cycle restart pulse to the level drawer.
module game_screen_sequencer #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned HOLD_FRAMES = 120
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       win,
  input  logic       lose,
  input  logic       jump_button,
  output logic [1:0] screen_sel,
  output logic       level_reset_n,
  output logic [1:0] lives,
  output logic [7:0] hold_frames_left
);

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_WIN  = 2'd1,
    S_LOSE = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       btn_prev_q, btn_prev_d;
  logic       press_q, press_d;
  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] hold_q, hold_d;
  logic       lrn_q, lrn_d;
  logic [7:0] hold_dec;
  logic       enter_play;

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    sync1_d    = jump_button;
    sync2_d    = sync1_q;
    btn_prev_d = sync2_q;
    press_d    = btn_prev_q & ~sync2_q;

    state_d  = state_q;
    armed_d  = armed_q;
    lives_d  = lives_q;
    hold_d   = hold_q;
    hold_dec = (frame_tick && hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;

    case (state_q)
      S_PLAY: begin
        hold_d = 8'd0;
        if (armed_q && win) begin
          state_d = S_WIN;
          hold_d  = HOLD_INIT;
        end else if (armed_q && lose) begin
          lives_d = lives_q - 2'd1;
          hold_d  = HOLD_INIT;
          state_d = (lives_q == 2'd1) ? S_OVER : S_LOSE;
        end else if (frame_tick) begin
          armed_d = 1'b1;
        end
      end
      S_WIN, S_OVER: begin
        if (press_q && hold_q == 8'd0) begin
          state_d = S_PLAY;
          lives_d = LIVES_INIT;
        end else begin
          hold_d = hold_dec;
        end
      end
      S_LOSE: begin
        if (hold_q == 8'd0) state_d = S_PLAY;
        else                hold_d  = hold_dec;
      end
      default: state_d = S_PLAY;
    endcase

    // Entering PLAY re-masks win/lose until the next frame tick inside PLAY.
    enter_play = (state_d == S_PLAY) && (state_q != S_PLAY);
    if (enter_play) begin
      armed_d = 1'b0;
      hold_d  = 8'd0;
    end
    lrn_d = ~enter_play;
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample together.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_prev_q <= 1'b1;
      press_q    <= 1'b0;
      state_q    <= S_PLAY;
      armed_q    <= 1'b0;
      lives_q    <= LIVES_INIT;
      hold_q     <= 8'd0;
      lrn_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
      state_q    <= state_d;
      armed_q    <= armed_d;
      lives_q    <= lives_d;
      hold_q     <= hold_d;
      lrn_q      <= lrn_d;
    end
  end

  assign screen_sel       = state_q;
  assign level_reset_n    = lrn_q;
  assign lives            = lives_q;
  assign hold_frames_left = hold_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Bench for game_screen_sequencer: a hand-written vector table, directed corner
// sequences and a randomized run compared against a cycle-level rules model.
module tb_game_screen_sequencer;

  localparam int H  = 4;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       reset, ft, w, l, btn;
  logic [1:0] sel, lives;
  logic       lrn;
  logic [7:0] hold;
  logic [1:0] sel_b, lives_b;
  logic       lrn_b;
  logic [7:0] hold_b;

  game_screen_sequencer #(.LIVES(LV), .HOLD_FRAMES(H)) dut (
    .vga_clock(clk), .reset(reset), .frame_tick(ft), .win(w), .lose(l),
    .jump_button(btn), .screen_sel(sel), .level_reset_n(lrn), .lives(lives),
    .hold_frames_left(hold)
  );

  game_screen_sequencer dut_b (
    .vga_clock(clk), .reset(reset), .frame_tick(ft), .win(w), .lose(l),
    .jump_button(btn), .screen_sel(sel_b), .level_reset_n(lrn_b), .lives(lives_b),
    .hold_frames_left(hold_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rules model: screen 0..3, lives, hold count, armed flag, and the last four
  // sampled button levels (press seen by the FSM = 1 then 0, four and three edges back).
  int m_mode, m_lives, m_hold;
  bit m_armed, m_lrn;
  bit m_h[4];

  task automatic model_reset();
    m_mode = 0; m_lives = LV; m_hold = 0; m_armed = 0; m_lrn = 0;
    for (int i = 0; i < 4; i++) m_h[i] = 1'b1;
  endtask

  task automatic model_edge();
    bit press, enter;
    press = m_h[3] && !m_h[2];
    m_h[3] = m_h[2]; m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = btn;
    enter = 0;
    case (m_mode)
      0: begin
        if (m_armed && w) begin
          m_mode = 1; m_hold = H;
        end else if (m_armed && l) begin
          m_lives = m_lives - 1;
          m_mode  = (m_lives == 0) ? 3 : 2;
          m_hold  = H;
        end else if (ft) m_armed = 1;
      end
      1, 3: begin
        if (press && m_hold == 0) begin
          m_mode = 0; m_lives = LV; enter = 1;
        end else if (ft && m_hold > 0) m_hold = m_hold - 1;
      end
      default: begin
        if (m_hold == 0) begin
          m_mode = 0; enter = 1;
        end else if (ft) m_hold = m_hold - 1;
      end
    endcase
    if (enter) m_armed = 0;
    m_lrn = !enter;
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_sel",   int'(sel),   m_mode);
    check("model_lives", int'(lives), m_lives);
    check("model_hold",  int'(hold),  m_hold);
    check("model_lrn",   int'(lrn),   int'(m_lrn));
  endtask

  task automatic set_in(input bit f, input bit wi, input bit lo);
    ft = f; w = wi; l = lo;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    check("rst_sel",   int'(sel),   0);
    check("rst_lives", int'(lives), LV);
    check("rst_hold",  int'(hold),  0);
    check("rst_lrn",   int'(lrn),   0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit f, wi, lo;
    int sel, lv, hold, lrn;
  } vec_t;
  vec_t tbl[13];

  int lrn_lows;

  initial begin
    reset = 1'b0; ft = 0; w = 0; l = 0; btn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset release with win held: nothing happens until a tick arms PLAY.
    reset = 1'b1;
    set_in(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("win_unarmed_sel_b", int'(sel_b), 0);
    end
    check("first_lrn_b", int'(lrn_b), 1);
    set_in(1, 1, 0);
    step();
    check("arm_tick_sel_b", int'(sel_b), 0);
    set_in(0, 1, 0);
    step();
    check("win_sel_b",  int'(sel_b),  1);
    check("win_hold_b", int'(hold_b), 120);
    set_in(0, 0, 0);
    reset_pulse();

    // Table: stale lose, tick-on-entry, LOSE auto-return, tick on PLAY entry, win priority.
    tbl[0]  = '{0, 0, 1, 0, 3, 0, 1};
    tbl[1]  = '{1, 0, 1, 0, 3, 0, 1};
    tbl[2]  = '{1, 0, 1, 2, 2, 4, 1};
    tbl[3]  = '{1, 0, 1, 2, 2, 3, 1};
    tbl[4]  = '{1, 0, 0, 2, 2, 2, 1};
    tbl[5]  = '{1, 0, 0, 2, 2, 1, 1};
    tbl[6]  = '{0, 0, 0, 2, 2, 1, 1};
    tbl[7]  = '{1, 0, 0, 2, 2, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 2, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 2, 0, 1};
    tbl[10] = '{1, 1, 0, 0, 2, 0, 1};
    tbl[11] = '{0, 1, 1, 1, 2, 4, 1};
    tbl[12] = '{1, 0, 0, 1, 2, 3, 1};
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].f, tbl[i].wi, tbl[i].lo);
      step();
      check($sformatf("tbl%0d_sel", i),   int'(sel),   tbl[i].sel);
      check($sformatf("tbl%0d_lives", i), int'(lives), tbl[i].lv);
      check($sformatf("tbl%0d_hold", i),  int'(hold),  tbl[i].hold);
      check($sformatf("tbl%0d_lrn", i),   int'(lrn),   tbl[i].lrn);
    end

    // WIN with hold count 3: an early press is discarded.
    set_in(0, 0, 0);
    btn = 1'b0;
    repeat (6) step();
    check("early_press_sel",  int'(sel),  1);
    check("early_press_hold", int'(hold), 3);
    btn = 1'b1;
    repeat (4) step();
    set_in(1, 0, 0);
    repeat (3) step();
    check("hold_zero", int'(hold), 0);
    set_in(0, 0, 0);

    // Press latency: screen_sel changes on the fourth edge after the button edge.
    btn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("press_lat%0d_sel", i), int'(sel), 1);
    end
    step();
    check("press_sel",   int'(sel),   0);
    check("press_lrn",   int'(lrn),   0);
    check("press_lives", int'(lives), 3);
    step();
    check("press_lrn_after", int'(lrn), 1);
    btn = 1'b1;
    repeat (4) step();

    // Button held low 1000 cycles in WIN with hold 0: exactly one restart.
    set_in(1, 0, 0); step();
    set_in(0, 1, 0); step();
    check("win2_sel", int'(sel), 1);
    set_in(1, 0, 0);
    repeat (H) step();
    set_in(0, 0, 0);
    btn = 1'b0;
    lrn_lows = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!lrn) lrn_lows++;
    end
    check("held_restarts", lrn_lows, 1);
    check("held_sel",      int'(sel), 0);
    btn = 1'b1;
    repeat (4) step();

    // Three armed lose events: LOSE, LOSE, then OVER with zero lives.
    for (int r = 0; r < 3; r++) begin
      set_in(1, 0, 0); step();
      set_in(0, 0, 1); step();
      check($sformatf("lose%0d_sel", r),   int'(sel),   (r == 2) ? 3 : 2);
      check($sformatf("lose%0d_lives", r), int'(lives), 2 - r);
      set_in(1, 0, 0);
      if (r < 2) begin
        repeat (H) step();
        check($sformatf("lose%0d_last_tick_sel", r), int'(sel), 2);
        set_in(0, 0, 0);
        step();
        check($sformatf("lose%0d_return_sel", r),   int'(sel),   0);
        check($sformatf("lose%0d_return_lrn", r),   int'(lrn),   0);
        check($sformatf("lose%0d_return_lives", r), int'(lives), 2 - r);
        step();
        check($sformatf("lose%0d_lrn_high", r), int'(lrn), 1);
      end
    end
    repeat (H) step();
    set_in(0, 0, 0);
    btn = 1'b0;
    repeat (4) step();
    check("over_restart_sel",   int'(sel),   0);
    check("over_restart_lives", int'(lives), 3);
    btn = 1'b1;
    repeat (4) step();

    // Reset mid-hold: outputs return at once, without waiting for a clock.
    set_in(1, 0, 0); step();
    set_in(0, 0, 1); step();
    set_in(1, 0, 0); step();
    check("pre_reset_hold", int'(hold), H - 1);
    set_in(0, 0, 0);
    #2;
    reset_pulse();

    // Randomized run against the rules model.
    for (int i = 0; i < 4000; i++) begin
      ft = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) btn = ~btn;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
